// File: rtl/mem_responder.sv
// mem_responder: memory-side endpoint of the CPU request/response interface.
// A word-addressed RAM accepts one request per cycle. A read samples the RAM
// at its accept edge, passes through a fixed READ_LATENCY shift pipeline and
// lands in a first-word-fallthrough response FIFO. Writes give no response.
// Flow control is credit based: a request is refused while RESP_DEPTH reads
// are outstanding, so the pipeline never stalls and the FIFO never overflows.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   mem_req_addr/we/data/be/valid -> mem_req_ready   request channel
//   mem_resp_data/valid <- mem_resp_ready            response channel
module mem_responder #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_WORDS    = 4096,
  parameter int READ_LATENCY = 2,
  parameter int RESP_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic                    mem_req_we,
  input  logic [DATA_WIDTH-1:0]   mem_req_data,
  input  logic [DATA_WIDTH/8-1:0] mem_req_be,
  input  logic                    mem_req_valid,
  output logic                    mem_req_ready,
  output logic [DATA_WIDTH-1:0]   mem_resp_data,
  output logic                    mem_resp_valid,
  input  logic                    mem_resp_ready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BO    = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IW    = $clog2(MEM_WORDS);
  localparam int PW    = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW    = $clog2(RESP_DEPTH + 1);

  logic [DATA_WIDTH-1:0]   ram [MEM_WORDS];
  logic [IW-1:0]           idx;
  logic                    accept;
  logic                    wr_acc;
  logic                    rd_acc;
  logic                    pop;
  logic                    push;

  logic [READ_LATENCY-1:0] pipe_vld;
  logic [DATA_WIDTH-1:0]   pipe_dat [READ_LATENCY];

  logic [DATA_WIDTH-1:0]   fifo_mem [RESP_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [CW-1:0]           fifo_cnt;
  logic [CW-1:0]           outstanding;

  // Offset and upper address bits are intentionally ignored (aliasing).
  logic                    unused_addr;
  assign unused_addr = ^mem_req_addr;

  assign idx    = mem_req_addr[BO +: IW];
  assign accept = mem_req_valid & mem_req_ready;
  assign wr_acc = accept & mem_req_we;
  assign rd_acc = accept & ~mem_req_we;
  assign pop    = mem_resp_valid & mem_resp_ready;
  assign push   = pipe_vld[READ_LATENCY-1];

  // Ready comes only from the credit counter, never from mem_req_valid.
  assign mem_req_ready  = (outstanding < CW'(RESP_DEPTH));
  assign mem_resp_valid = (fifo_cnt != '0);
  assign mem_resp_data  = mem_resp_valid ? fifo_mem[rd_ptr] : '0;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // RAM is not reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int b = 0; b < BYTES; b++) begin
        if (mem_req_be[b]) ram[idx][b*8 +: 8] <= mem_req_data[b*8 +: 8];
      end
    end
  end

  // Read pipeline. Stage 0 samples the RAM before this edge's update, which
  // is safe because a read and a write can never be accepted on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_dat[i] <= '0;
    end else begin
      pipe_vld[0] <= rd_acc;
      if (rd_acc) pipe_dat[0] <= ram[idx];
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= pipe_dat[READ_LATENCY-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Credits: reads accepted but not yet popped (in pipeline or FIFO).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({rd_acc, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  localparam int MW = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] resp_data;
  logic        resp_valid;
  logic        resp_ready = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pop_total = 0;
  int pop_cyc [$];
  logic [31:0] sb [$];
  logic [31:0] model [MW];
  logic [31:0] mon_exp;

  mem_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req_addr   (addr),
    .mem_req_we     (we),
    .mem_req_data   (wdata),
    .mem_req_be     (be),
    .mem_req_valid  (req_valid),
    .mem_req_ready  (req_ready),
    .mem_resp_data  (resp_data),
    .mem_resp_valid (resp_valid),
    .mem_resp_ready (resp_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard pop: compare every consumed response against the queue.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL stale_resp: got %h, nothing expected", resp_data);
      end else begin
        mon_exp = sb.pop_front();
        if (resp_data !== mon_exp) begin
          bad++;
          $display("FAIL resp_data: got %h, expected %h", resp_data, mon_exp);
        end
      end
      pop_total++;
      pop_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [31:0] ta, input logic tw, input logic [31:0] td,
                       input logic [3:0] tbe, output int waits);
    bit r;
    bit done;
    waits = 0;
    done = 0;
    addr = ta; we = tw; wdata = td; be = tbe; req_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      r = req_ready;
      @(posedge clk);
      if (r) begin
        done = 1;
        if (tw) begin
          for (int b = 0; b < 4; b++)
            if (tbe[b]) model[ta[13:2]][b*8 +: 8] = td[b*8 +: 8];
        end else begin
          sb.push_back(model[ta[13:2]]);
        end
      end else begin
        waits++;
        if (waits > 50) begin
          total++; bad++;
          $display("FAIL accept_timeout: addr %h not accepted", ta);
          done = 1;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    we = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || resp_valid) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (sb.size() != 0 || resp_valid) begin
      bad++;
      $display("FAIL drain_timeout: pending=%0d valid=%b", sb.size(), resp_valid);
    end
  endtask

  task automatic test_reset();
    resp_ready = 1'b0;
    #12;
    total++;
    if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b, expected 0", resp_valid); end
    total++;
    if (resp_data !== 32'h0) begin bad++; $display("FAIL rst_data: got %h, expected 0", resp_data); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b, expected 1", req_ready); end
  endtask

  task automatic test_write_read();
    int w;
    resp_ready = 1'b1;
    issue(32'h10, 1'b1, 32'h11223344, 4'hF, w);
    issue(32'h10, 1'b0, 32'h0, 4'h0, w);
    idle();
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0) begin bad++; $display("FAIL lat_n0: valid got %b, expected 0", resp_valid); end
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0) begin bad++; $display("FAIL lat_n1: valid got %b, expected 0", resp_valid); end
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b1 || resp_data !== 32'h11223344) begin
      bad++;
      $display("FAIL lat_n2: valid=%b data=%h, expected 1 / 11223344", resp_valid, resp_data);
    end
    wait_drain(20);
  endtask

  task automatic test_partial();
    int w;
    int n;
    resp_ready = 1'b1;
    issue(32'h10, 1'b1, 32'hAABBCCDD, 4'b0101, w);
    issue(32'h10, 1'b0, 32'h0, 4'h0, w);
    issue(32'h10 + MW*4, 1'b0, 32'h0, 4'h0, w);
    idle();
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    total++;
    if (resp_data !== 32'h11BB33DD) begin bad++; $display("FAIL partial: got %h, expected 11bb33dd", resp_data); end
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b1 || resp_data !== 32'h11BB33DD) begin
      bad++;
      $display("FAIL alias: valid=%b data=%h, expected 1 / 11bb33dd", resp_valid, resp_data);
    end
    wait_drain(20);
  endtask

  task automatic test_backpressure();
    int w;
    int p;
    resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) issue(32'h100 + i*4, 1'b1, 32'hB000_0000 + i, 4'hF, w);
    resp_ready = 1'b0;
    p = pop_total;
    for (int i = 0; i < 4; i++) begin
      issue(32'h100 + i*4, 1'b0, 32'h0, 4'h0, w);
      total++;
      if (w != 0) begin bad++; $display("FAIL bp_accept%0d: waits=%0d, expected 0", i, w); end
    end
    addr = 32'h110; we = 1'b0; req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready%0d: got %b, expected 0", k, req_ready); end
      total++;
      if (resp_valid !== 1'b1 || resp_data !== 32'hB000_0000) begin
        bad++;
        $display("FAIL bp_hold%0d: valid=%b data=%h, expected 1 / b0000000", k, resp_valid, resp_data);
      end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    issue(32'h110, 1'b0, 32'h0, 4'h0, w);
    issue(32'h114, 1'b0, 32'h0, 4'h0, w);
    idle();
    wait_drain(40);
    total++;
    if (pop_total - p != 6) begin bad++; $display("FAIL bp_count: got %0d, expected 6", pop_total - p); end
  endtask

  task automatic test_streaming();
    int w;
    int sum_w;
    resp_ready = 1'b1;
    for (int i = 0; i < 16; i++) issue(i*4, 1'b1, 32'h5000_0000 + i*32'h1111, 4'hF, w);
    wait_drain(10);
    pop_cyc.delete();
    sum_w = 0;
    for (int i = 0; i < 16; i++) begin
      issue(i*4, 1'b0, 32'h0, 4'h0, w);
      sum_w += w;
    end
    idle();
    total++;
    if (sum_w != 0) begin bad++; $display("FAIL stream_ready: stall cycles=%0d, expected 0", sum_w); end
    wait_drain(40);
    total++;
    if (pop_cyc.size() != 16) begin
      bad++;
      $display("FAIL stream_count: got %0d, expected 16", pop_cyc.size());
    end else begin
      total++;
      if (pop_cyc[15] - pop_cyc[0] != 15) begin
        bad++;
        $display("FAIL stream_rate: span=%0d cycles, expected 15", pop_cyc[15] - pop_cyc[0]);
      end
    end
  endtask

  task automatic test_interleave();
    int w;
    int p;
    resp_ready = 1'b1;
    p = pop_total;
    issue(32'h80, 1'b1, 32'hAAAA_0001, 4'hF, w);
    issue(32'h80, 1'b0, 32'h0, 4'h0, w);
    issue(32'h80, 1'b1, 32'hBBBB_0002, 4'hF, w);
    issue(32'h80, 1'b0, 32'h0, 4'h0, w);
    issue(32'h80, 1'b1, 32'hCCCC_0003, 4'hF, w);
    idle();
    wait_drain(20);
    total++;
    if (pop_total - p != 2) begin bad++; $display("FAIL intl_count: got %0d, expected 2", pop_total - p); end
  endtask

  task automatic test_reset_midflight();
    int w;
    resp_ready = 1'b1;
    issue(32'h40, 1'b1, 32'h4040_4040, 4'hF, w);
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(32'h40, 1'b0, 32'h0, 4'h0, w);
    idle();
    total++;
    if (resp_valid !== 1'b1) begin bad++; $display("FAIL mid_pre: valid got %b, expected 1", resp_valid); end
    rst_n = 1'b0;
    #1;
    total++;
    if (resp_valid !== 1'b0 || resp_data !== 32'h0) begin
      bad++;
      $display("FAIL mid_rst: valid=%b data=%h, expected 0 / 0", resp_valid, resp_data);
    end
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b, expected 1", req_ready); end
    resp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++;
      if (resp_valid !== 1'b0) begin bad++; $display("FAIL mid_stale%0d: valid got %b, expected 0", k, resp_valid); end
    end
    @(posedge clk); #1;
    issue(32'h40, 1'b0, 32'h0, 4'h0, w);
    idle();
    wait_drain(20);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial();
    test_backpressure();
    test_streaming();
    test_interleave();
    test_reset_midflight();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
